// File: rtl/adc_frame_serializer.sv
// Buffers corrected ADC codes in a small FIFO and streams each one on a single pin as
// a frame of header, MSB-first data and an even-parity bit.
module adc_frame_serializer #(
    parameter int               DW         = 13,
    parameter int               FIFO_DEPTH = 4,
    parameter int               HDR_W      = 3,
    parameter logic [HDR_W-1:0] HDR_PAT    = 3'b101
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DW-1:0]                 din,
    input  logic                          din_valid,
    input  logic                          en,
    input  logic                          ovf_clr,
    output logic                          sdo,
    output logic                          sframe,
    output logic                          ssync,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
    output logic                          ovf
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int FRAME_W = HDR_W + DW + 1;
    localparam int CW      = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_PAR
    } state_t;

    // The whole frame is assembled at pop time so the parity always matches the popped word.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [DW-1:0] word);
        return {HDR_PAT, word, ^word};
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [LW-1:0]       r_lvl;
    logic                r_ovf;

    logic [FRAME_W-1:0]  r_shift;
    logic [CW-1:0]       r_cnt;

    logic                r_sdo;
    logic                r_sframe;
    logic                r_ssync;

    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_sdo_nxt;
    logic                w_sframe_nxt;
    logic                w_ssync_nxt;

    assign w_full = (r_lvl == LW'(FIFO_DEPTH));
    assign w_pop  = ((r_state == S_IDLE) || (r_state == S_PAR)) && en && (r_lvl != '0);
    // A pop on the same edge frees the slot, so a full FIFO can still accept the sample.
    assign w_push = din_valid && (!w_full || w_pop);
    assign w_drop = din_valid && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (r_cnt == CW'(HDR_W - 1)) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_cnt == CW'(HDR_W + DW - 1)) w_state_nxt = S_PAR;
            end
            S_PAR: begin
                w_state_nxt = w_pop ? S_HDR : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sdo_nxt    = 1'b0;
        w_sframe_nxt = 1'b0;
        w_ssync_nxt  = 1'b0;
        if (r_state != S_IDLE) begin
            w_sdo_nxt    = r_shift[FRAME_W-1];
            w_sframe_nxt = 1'b1;
            w_ssync_nxt  = (r_state == S_HDR) && (r_cnt == '0);
        end
    end

    // Control path: FSM, pointers, level, flags and output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_lvl    <= '0;
            r_ovf    <= 1'b0;
            r_sdo    <= 1'b0;
            r_sframe <= 1'b0;
            r_ssync  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_pop) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);

            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + LW'(1);
                2'b01:   r_lvl <= r_lvl - LW'(1);
                default: r_lvl <= r_lvl;
            endcase

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            r_sdo    <= w_sdo_nxt;
            r_sframe <= w_sframe_nxt;
            r_ssync  <= w_ssync_nxt;
        end
    end

    // Data path: FIFO storage and frame shift register
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;

        if (w_pop) begin
            r_shift <= build_frame(r_mem[r_rptr]);
        end else begin
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
        end
    end

    assign sdo      = r_sdo;
    assign sframe   = r_sframe;
    assign ssync    = r_ssync;
    assign fifo_lvl = r_lvl;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Directed bench for adc_frame_serializer: reset, single and back-to-back frames,
// overflow and ovf_clr priority, full-plus-pop, and reset during an active frame.
module tb_adc_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] din;
    logic        din_valid;
    logic        en;
    logic        ovf_clr;
    logic        sdo;
    logic        sframe;
    logic        ssync;
    logic [2:0]  fifo_lvl;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_frame_serializer #(
        .DW(13),
        .FIFO_DEPTH(4),
        .HDR_W(3),
        .HDR_PAT(3'b101)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .en(en),
        .ovf_clr(ovf_clr),
        .sdo(sdo),
        .sframe(sframe),
        .ssync(ssync),
        .fifo_lvl(fifo_lvl),
        .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mkframe(input logic [12:0] d);
        return {3'b101, d, ^d};
    endfunction

    // Called when the first header bit is already on sdo; returns one cycle past the frame.
    task automatic check_frame(input logic [16:0] f, input string tag);
        for (int i = 0; i < 17; i++) begin
            chk({tag, "_sframe"}, {31'd0, sframe}, 32'd1);
            chk({tag, "_sdo"},    {31'd0, sdo},    {31'd0, f[16-i]});
            chk({tag, "_ssync"},  {31'd0, ssync},  {31'd0, (i == 0)});
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b0;
        ovf_clr   = 1'b0;

        // Power-up reset
        tick();
        tick();
        chk("rst_sdo",    {31'd0, sdo},    32'd0);
        chk("rst_sframe", {31'd0, sframe}, 32'd0);
        chk("rst_ssync",  {31'd0, ssync},  32'd0);
        chk("rst_lvl",    {29'd0, fifo_lvl}, 32'd0);
        chk("rst_ovf",    {31'd0, ovf},    32'd0);
        rst = 1'b0;
        tick();

        // Single sample 0x0ABC: 101 | 0_1010_1011_1100 | 1
        en        = 1'b1;
        din       = 13'h0ABC;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("single_lvl_push",  {29'd0, fifo_lvl}, 32'd1);
        chk("single_sframe_n0", {31'd0, sframe},   32'd0);
        tick();
        chk("single_lvl_pop",   {29'd0, fifo_lvl}, 32'd0);
        chk("single_sframe_n1", {31'd0, sframe},   32'd0);
        chk("single_ssync_n1",  {31'd0, ssync},    32'd0);
        tick();
        check_frame(17'b101_0101010111100_1, "single");
        chk("single_end_sframe", {31'd0, sframe}, 32'd0);
        chk("single_end_sdo",    {31'd0, sdo},    32'd0);

        // Back-to-back: 0x0000 then 0x1FFF, contiguous frames
        din       = 13'h0000;
        din_valid = 1'b1;
        tick();
        din       = 13'h1FFF;
        tick();
        din_valid = 1'b0;
        chk("b2b_lvl", {29'd0, fifo_lvl}, 32'd1);
        tick();
        check_frame(17'b101_0000000000000_0, "b2b_f0");
        check_frame(17'b101_1111111111111_1, "b2b_f1");
        chk("b2b_end_sframe", {31'd0, sframe}, 32'd0);

        // Overflow with en=0, then ovf_clr priority
        en        = 1'b0;
        din_valid = 1'b1;
        din = 13'h0001; tick();
        din = 13'h0123; tick();
        din = 13'h1555; tick();
        din = 13'h0AAA; tick();
        chk("ovf_lvl_full", {29'd0, fifo_lvl}, 32'd4);
        chk("ovf_not_yet",  {31'd0, ovf},      32'd0);
        din = 13'h1F00; tick();
        chk("ovf_lvl_drop", {29'd0, fifo_lvl}, 32'd4);
        chk("ovf_set",      {31'd0, ovf},      32'd1);
        din     = 13'h0777;
        ovf_clr = 1'b1;
        tick();
        chk("ovf_clr_vs_drop", {31'd0, ovf}, 32'd1);
        din_valid = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_alone", {31'd0, ovf}, 32'd0);
        chk("ovf_lvl_hold",  {29'd0, fifo_lvl}, 32'd4);
        tick();
        chk("ovf_idle_sframe", {31'd0, sframe}, 32'd0);

        en = 1'b1;
        tick();
        chk("ovf_lvl_first_pop", {29'd0, fifo_lvl}, 32'd3);
        chk("ovf_sframe_pop",    {31'd0, sframe},   32'd0);
        tick();
        check_frame(mkframe(13'h0001), "ovf_s1");
        check_frame(mkframe(13'h0123), "ovf_s2");
        check_frame(mkframe(13'h1555), "ovf_s3");
        check_frame(mkframe(13'h0AAA), "ovf_s4");
        chk("ovf_drain_sframe", {31'd0, sframe},   32'd0);
        chk("ovf_drain_lvl",    {29'd0, fifo_lvl}, 32'd0);

        // Full plus pop at the PAR exit
        din_valid = 1'b1;
        din = 13'h0F0F; tick();
        din = 13'h0011; tick();
        din = 13'h0022; tick();
        din = 13'h0033; tick();
        din = 13'h0044; tick();
        din_valid = 1'b0;
        chk("fp_lvl_full", {29'd0, fifo_lvl}, 32'd4);
        for (int i = 0; i < 13; i++) tick();
        chk("fp_lvl_before", {29'd0, fifo_lvl}, 32'd4);
        chk("fp_par_sframe", {31'd0, sframe},   32'd1);
        din       = 13'h1234;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("fp_lvl_after", {29'd0, fifo_lvl}, 32'd4);
        chk("fp_ovf",       {31'd0, ovf},      32'd0);
        chk("fp_par_bit",   {31'd0, sdo},      32'd0);
        tick();
        chk("fp_next_ssync",  {31'd0, ssync},  32'd1);
        chk("fp_next_sframe", {31'd0, sframe}, 32'd1);
        for (int i = 0; i < 85; i++) tick();
        chk("fp_drain_sframe", {31'd0, sframe},   32'd0);
        chk("fp_drain_lvl",    {29'd0, fifo_lvl}, 32'd0);
        chk("fp_drain_ovf",    {31'd0, ovf},      32'd0);

        // Reset during an active frame with ovf set and FIFO occupied
        en        = 1'b0;
        din_valid = 1'b1;
        din = 13'h0101; tick();
        din = 13'h0202; tick();
        din = 13'h0303; tick();
        din = 13'h0404; tick();
        din = 13'h0505; tick();
        din_valid = 1'b0;
        chk("mr_ovf_pre", {31'd0, ovf}, 32'd1);
        en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("mr_active", {31'd0, sframe}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_sdo",    {31'd0, sdo},      32'd0);
        chk("mr_sframe", {31'd0, sframe},   32'd0);
        chk("mr_ssync",  {31'd0, ssync},    32'd0);
        chk("mr_lvl",    {29'd0, fifo_lvl}, 32'd0);
        chk("mr_ovf",    {31'd0, ovf},      32'd0);
        tick();
        chk("mr2_sframe", {31'd0, sframe},   32'd0);
        chk("mr2_lvl",    {29'd0, fifo_lvl}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("mr_post_sframe", {31'd0, sframe},   32'd0);
        chk("mr_post_lvl",    {29'd0, fifo_lvl}, 32'd0);
        chk("mr_post_ovf",    {31'd0, ovf},      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
